// File: rtl/gapl_header_sequencer_if.sv
// Handshake and status bundle between the header/body split, the body processor and downstream.
// The slave modport is the sequencer's view; master is the surrounding logic's view.
interface gapl_header_sequencer_if #(
  parameter int unsigned HeaderWidth = 192,
  parameter int unsigned Depth       = 4,
  parameter int unsigned CntWidth    = 32
);
  localparam int unsigned OccW = $clog2(Depth) + 1;

  logic [HeaderWidth-1:0] hdr_in;
  logic                   in_tvalid;
  logic                   in_tlast;
  logic                   in_tready;
  logic                   proc_in_tvalid;
  logic                   proc_in_tready;
  logic                   proc_out_tvalid;
  logic                   proc_out_tlast;
  logic                   proc_out_tready;
  logic                   out_tvalid;
  logic                   out_tready;
  logic [HeaderWidth-1:0] hdr_out;
  logic                   hdr_out_valid;
  logic [OccW-1:0]        occupancy;
  logic [CntWidth-1:0]    pkts_in;
  logic [CntWidth-1:0]    pkts_out;

  modport slave (
    input  hdr_in, in_tvalid, in_tlast, proc_in_tready,
    input  proc_out_tvalid, proc_out_tlast, out_tready,
    output in_tready, proc_in_tvalid, proc_out_tready, out_tvalid,
    output hdr_out, hdr_out_valid, occupancy, pkts_in, pkts_out
  );

  modport master (
    output hdr_in, in_tvalid, in_tlast, proc_in_tready,
    output proc_out_tvalid, proc_out_tlast, out_tready,
    input  in_tready, proc_in_tvalid, proc_out_tready, out_tvalid,
    input  hdr_out, hdr_out_valid, occupancy, pkts_in, pkts_out
  );
endinterface

// File: rtl/gapl_header_sequencer.sv
// Header FIFO that keeps packet headers aligned with bodies across a variable-latency body
// processor: push on the first accepted input beat, pop on the last accepted output beat.
module gapl_header_sequencer #(
  parameter int unsigned HeaderWidth = 192,
  parameter int unsigned Depth       = 4,
  parameter int unsigned CntWidth    = 32
) (
  input logic                    clock,
  input logic                    reset,
  gapl_header_sequencer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = PtrW + 1;

  typedef enum logic {StSop, StBody} in_state_e;

  in_state_e              in_state_q, in_state_d;
  logic [HeaderWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]        occ_q, occ_d;
  logic [CntWidth-1:0]    pkts_in_q, pkts_in_d;
  logic [CntWidth-1:0]    pkts_out_q, pkts_out_d;

  logic in_sop, full, empty, block;
  logic in_acc, out_acc, push, pop;

  assign in_sop = (in_state_q == StSop);
  // full/empty come from registered occupancy only, so a same-cycle pop never frees a slot
  assign full   = (occ_q == OccW'(Depth));
  assign empty  = (occ_q == '0);
  assign block  = in_sop & full;

  assign bus.proc_in_tvalid  = bus.in_tvalid & ~block;
  assign bus.in_tready       = bus.proc_in_tready & ~block;
  assign in_acc              = bus.in_tvalid & bus.in_tready;
  assign push                = in_acc & in_sop;

  assign bus.out_tvalid      = bus.proc_out_tvalid & ~empty;
  assign bus.proc_out_tready = bus.out_tready & ~empty;
  assign out_acc             = bus.out_tvalid & bus.out_tready;
  assign pop                 = out_acc & bus.proc_out_tlast;

  assign bus.hdr_out       = mem_q[rd_ptr_q];
  assign bus.hdr_out_valid = ~empty;
  assign bus.occupancy     = occ_q;
  assign bus.pkts_in       = pkts_in_q;
  assign bus.pkts_out      = pkts_out_q;

  always_comb begin
    in_state_d = in_state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    pkts_in_d  = pkts_in_q;
    pkts_out_d = pkts_out_q;

    if (in_acc) begin
      in_state_d = bus.in_tlast ? StSop : StBody;
    end
    if (push) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      pkts_in_d = pkts_in_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      pkts_out_d = pkts_out_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_state_q <= StSop;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      pkts_in_q  <= '0;
      pkts_out_q <= '0;
    end else begin
      in_state_q <= in_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pkts_in_q  <= pkts_in_d;
      pkts_out_q <= pkts_out_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.hdr_in;
    end
  end
endmodule
